// File: rtl/lif_pkg.sv
// Shared constants and types for the time-multiplexed LIF neuron scheduler.
// The scheduler, its bus interface and the bench all size themselves from here.
package lif_pkg;

  localparam int N_NEURONS  = 4;
  localparam int STATE_W    = 8;
  localparam int BETA_SHIFT = 2;
  localparam int IDX_W      = $clog2(N_NEURONS);

  typedef logic [STATE_W-1:0] mem_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXEC,
    DONE
  } state_t;

endpackage

// File: rtl/lif_scheduler_if.sv
// Control/data bundle between the pin wrapper (master) and the scheduler (slave).
// The master owns the strobe, threshold, current feed and monitor select.
interface lif_scheduler_if;
  import lif_pkg::*;

  logic                 step;
  mem_t                 thresh;
  mem_t                 cur_in;
  logic [IDX_W-1:0]     mon_sel;
  logic [IDX_W-1:0]     cur_idx;
  logic                 busy;
  logic                 done;
  logic [N_NEURONS-1:0] spikes;
  mem_t                 mon_state;

  modport master (
    output step, thresh, cur_in, mon_sel,
    input  cur_idx, busy, done, spikes, mon_state
  );

  modport slave (
    input  step, thresh, cur_in, mon_sel,
    output cur_idx, busy, done, spikes, mon_state
  );

endinterface

// File: rtl/lif_update.sv
// Combinational leak/integrate/threshold step for one neuron.
// Shared by the multiplexed scheduler and the single-neuron wrapper.
module lif_update
  import lif_pkg::*;
#(
  parameter int W     = STATE_W,
  parameter int SHIFT = BETA_SHIFT
) (
  input  logic [W-1:0] i_mem,
  input  logic [W-1:0] i_cur,
  input  logic [W-1:0] i_thr,
  output logic [W-1:0] o_next_mem,
  output logic         o_fire
);

  logic [W-1:0] w_leaked;
  logic [W:0]   w_sum;
  logic [W-1:0] w_sat;

  // A zero threshold disables firing so membranes can be preloaded.
  always_comb begin
    w_leaked   = i_mem - (i_mem >> SHIFT);
    w_sum      = {1'b0, w_leaked} + {1'b0, i_cur};
    w_sat      = w_sum[W] ? '1 : w_sum[W-1:0];
    o_fire     = (i_thr != '0) && (w_sat >= i_thr);
    o_next_mem = o_fire ? '0 : w_sat;
  end

endmodule

// File: rtl/lif_scheduler.sv
// Sequences N_NEURONS virtual neurons through one lif_update datapath per timestep,
// holding membranes in a register file and publishing the spike vector per pass.
module lif_scheduler
  import lif_pkg::*;
(
  input logic             clk,
  input logic             rst,
  lif_scheduler_if.slave  bus
);

  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  mem_t                 r_mem [N_NEURONS];
  mem_t                 r_curQ;
  mem_t                 r_memQ;
  mem_t                 r_thrQ;
  logic [N_NEURONS-1:0] r_spkAcc;
  logic [N_NEURONS-1:0] r_spikes;
  logic                 r_busy;
  logic                 r_done;

  mem_t                 w_nextMem;
  logic                 w_fire;
  logic [N_NEURONS-1:0] w_spkNext;

  lif_update #(
    .W     (STATE_W),
    .SHIFT (BETA_SHIFT)
  ) u_update (
    .i_mem      (r_memQ),
    .i_cur      (r_curQ),
    .i_thr      (r_thrQ),
    .o_next_mem (w_nextMem),
    .o_fire     (w_fire)
  );

  // Spike accumulator including the neuron being written back this cycle,
  // so the last neuron's result reaches the published vector at the same edge.
  always_comb begin
    w_spkNext        = r_spkAcc;
    w_spkNext[r_idx] = w_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_curQ   <= '0;
      r_memQ   <= '0;
      r_thrQ   <= '0;
      r_spkAcc <= '0;
      r_spikes <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.step) begin
            r_thrQ  <= bus.thresh;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_curQ  <= bus.cur_in;
          r_memQ  <= r_mem[r_idx];
          r_state <= EXEC;
        end
        EXEC: begin
          r_mem[r_idx] <= w_nextMem;
          r_spkAcc     <= w_spkNext;
          if (r_idx == IDX_W'(N_NEURONS - 1)) begin
            r_spikes <= w_spkNext;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= LOAD;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cur_idx   = r_idx;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.spikes    = r_spikes;
  assign bus.mon_state = r_mem[bus.mon_sel];

endmodule

// File: tb/tb_lif_scheduler.sv
// Randomized self-checking bench for lif_scheduler against a per-pass arithmetic
// model of the membranes and spike vector, plus the directed scenarios.
module tb_lif_scheduler;
  import lif_pkg::*;

  logic clk;
  logic rst;
  int   nChecks;
  int   nErrors;

  mem_t                 curTable   [N_NEURONS];
  int                   modelMem   [N_NEURONS];
  logic [N_NEURONS-1:0] modelSpikes;

  lif_scheduler_if sif ();

  lif_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  // The current source decodes cur_idx combinationally.
  assign sif.cur_in = curTable[sif.cur_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N_NEURONS; i++) modelMem[i] = 0;
    modelSpikes = '0;
  endtask

  // One timestep: leak by a fraction, add current, clip, compare to threshold.
  task automatic modelPass(input int thr);
    int s;
    for (int i = 0; i < N_NEURONS; i++) begin
      s = modelMem[i] - modelMem[i] / (1 << BETA_SHIFT) + int'(curTable[i]);
      if (s > (1 << STATE_W) - 1) s = (1 << STATE_W) - 1;
      if (thr != 0 && s >= thr) begin
        modelMem[i]    = 0;
        modelSpikes[i] = 1'b1;
      end else begin
        modelMem[i]    = s;
        modelSpikes[i] = 1'b0;
      end
    end
  endtask

  task automatic checkModelState();
    checkOutput("spikes", 32'(sif.spikes), 32'(modelSpikes));
    for (int i = 0; i < N_NEURONS; i++) begin
      sif.mon_sel = IDX_W'(i);
      #1;
      checkOutput($sformatf("mon%0d", i), 32'(sif.mon_state), 32'(modelMem[i]));
    end
  endtask

  task automatic readMon(input int n, output int val);
    sif.mon_sel = IDX_W'(n);
    #1;
    val = int'(sif.mon_state);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst      = 1'b1;
    sif.step = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  // One full pass: strobe, verify cur_idx/latency, then compare against the model.
  task automatic applyStimulus(input int thr, input int c0, input int c1, input int c2, input int c3);
    bit seen;
    curTable[0] = mem_t'(c0);
    curTable[1] = mem_t'(c1);
    curTable[2] = mem_t'(c2);
    curTable[3] = mem_t'(c3);
    @(negedge clk);
    sif.thresh = mem_t'(thr);
    sif.step   = 1'b1;
    @(posedge clk);
    #1;
    sif.step   = 1'b0;
    sif.thresh = mem_t'($urandom);
    checkOutput("busyAfterAccept", 32'(sif.busy), 1);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (k < 2 * N_NEURONS && k % 2 == 0)
        checkOutput("curIdxLoad", 32'(sif.cur_idx), 32'(k / 2));
      if (sif.done) begin
        checkOutput("doneLatency", 32'(k), 32'(2 * N_NEURONS));
        seen = 1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!seen) checkOutput("doneSeen", 0, 1);
    modelPass(thr);
    checkModelState();
    @(posedge clk);
    #1;
    checkOutput("doneOnePulse", 32'(sif.done), 0);
    checkOutput("busyAfterDone", 32'(sif.busy), 0);
  endtask

  initial begin
    int expMon [6];
    int val;
    int doneCount;
    int lastDone;
    int thrR;

    nChecks    = 0;
    nErrors    = 0;
    rst        = 1'b1;
    sif.step   = 1'b0;
    sif.thresh = '0;
    sif.mon_sel = '0;
    for (int i = 0; i < N_NEURONS; i++) curTable[i] = '0;
    modelReset();
    doReset();

    checkOutput("rstSpikes", 32'(sif.spikes), 0);
    checkOutput("rstBusy", 32'(sif.busy), 0);
    checkOutput("rstDone", 32'(sif.done), 0);
    checkOutput("rstCurIdx", 32'(sif.cur_idx), 0);
    for (int i = 0; i < N_NEURONS; i++) begin
      readMon(i, val);
      checkOutput($sformatf("rstMon%0d", i), 32'(val), 0);
    end

    // Integrate-to-fire on neuron 0.
    expMon = '{30, 53, 70, 83, 93, 0};
    for (int s = 0; s < 6; s++) begin
      applyStimulus(100, 30, 0, 0, 0);
      readMon(0, val);
      checkOutput($sformatf("integrateStep%0d", s + 1), 32'(val), 32'(expMon[s]));
    end
    checkOutput("integrateSpike", 32'(sif.spikes[0]), 1);

    // Per-neuron currents from reset.
    doReset();
    applyStimulus(120, 0, 50, 100, 150);
    checkOutput("perNeuronSpikes", 32'(sif.spikes), 32'(4'b1000));
    readMon(1, val);
    checkOutput("perNeuronMon1", 32'(val), 50);
    readMon(2, val);
    checkOutput("perNeuronMon2", 32'(val), 100);

    // Saturation on neuron 2.
    doReset();
    applyStimulus(0, 0, 0, 200, 0);
    applyStimulus(0, 0, 0, 255, 0);
    readMon(2, val);
    checkOutput("satState", 32'(val), 255);
    checkOutput("satNoSpike", 32'(sif.spikes[2]), 0);
    applyStimulus(255, 0, 0, 255, 0);
    readMon(2, val);
    checkOutput("satFireState", 32'(val), 0);
    checkOutput("satFireSpike", 32'(sif.spikes[2]), 1);

    // Randomized passes.
    for (int p = 0; p < 24; p++) begin
      thrR = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
      applyStimulus(thrR, int'($urandom_range(0, 90)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 40)), int'($urandom_range(0, 255)));
    end

    // step held high: one pass every 2N+2 cycles, extra strobes ignored.
    for (int i = 0; i < N_NEURONS; i++) curTable[i] = mem_t'($urandom_range(0, 120));
    thrR = int'($urandom_range(60, 200));
    @(negedge clk);
    sif.thresh = mem_t'(thrR);
    sif.step   = 1'b1;
    doneCount  = 0;
    lastDone   = -1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (sif.done) begin
        doneCount++;
        if (lastDone >= 0) checkOutput("heldPeriod", 32'(k - lastDone), 32'(2 * N_NEURONS + 2));
        lastDone = k;
      end
    end
    sif.step = 1'b0;
    checkOutput("heldDoneCount", 32'(doneCount), 3);
    for (int p = 0; p < 3; p++) modelPass(thrR);
    checkModelState();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("heldIdleBusy", 32'(sif.busy), 0);

    // Reset during EXEC of neuron 1 discards the pass.
    for (int i = 0; i < N_NEURONS; i++) curTable[i] = mem_t'($urandom_range(1, 255));
    @(negedge clk);
    sif.thresh = 8'd1;
    sif.step   = 1'b1;
    @(posedge clk);
    #1;
    sif.step = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midPassIdx", 32'(sif.cur_idx), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    checkOutput("midRstBusy", 32'(sif.busy), 0);
    checkOutput("midRstDone", 32'(sif.done), 0);
    checkModelState();
    doneCount = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (sif.done) doneCount++;
    end
    checkOutput("midRstNoDone", 32'(doneCount), 0);
    checkOutput("midRstSpikes", 32'(sif.spikes), 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
